// File: rtl/debounce.sv
// Pushbutton/switch debouncer: commits a level change on q only after STABLE
// consecutive samples of the new level. Define DEBOUNCE_SYNC_EN to add a 2-flop input synchronizer.
module debounce #(
    parameter int STABLE = 4,
    parameter int CW     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic d_raw,
    output logic q,
    output logic busy
);

    typedef enum logic [1:0] {
        ST_LOW  = 2'b00,
        ST_RISE = 2'b01,
        ST_HIGH = 2'b10,
        ST_FALL = 2'b11
    } state_t;

    localparam logic [CW-1:0] LP_LAST = CW'(STABLE - 1);
    localparam logic [CW-1:0] LP_ONE  = CW'(1);
    localparam logic [CW-1:0] LP_ZERO = CW'(0);

    logic w_s;

`ifdef DEBOUNCE_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-flop chain bringing the asynchronous level into the clk domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= d_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = d_raw;
`endif

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_q;
    logic          r_busy;

    // Qualification FSM; q/busy are registered alongside the state they decode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_LOW;
            r_cnt   <= LP_ZERO;
            r_q     <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_LOW: begin
                    if (w_s) begin
                        r_state <= ST_RISE;
                        r_cnt   <= LP_ONE;
                        r_q     <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_LOW;
                        r_cnt   <= LP_ZERO;
                        r_q     <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                ST_RISE: begin
                    if (!w_s) begin
                        r_state <= ST_LOW;
                        r_cnt   <= LP_ZERO;
                        r_q     <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == LP_LAST) begin
                        r_state <= ST_HIGH;
                        r_cnt   <= LP_ZERO;
                        r_q     <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_RISE;
                        r_cnt   <= r_cnt + LP_ONE;
                        r_q     <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!w_s) begin
                        r_state <= ST_FALL;
                        r_cnt   <= LP_ONE;
                        r_q     <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_HIGH;
                        r_cnt   <= r_cnt;
                        r_q     <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_FALL: begin
                    if (w_s) begin
                        r_state <= ST_HIGH;
                        r_cnt   <= LP_ZERO;
                        r_q     <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == LP_LAST) begin
                        r_state <= ST_LOW;
                        r_cnt   <= LP_ZERO;
                        r_q     <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_FALL;
                        r_cnt   <= r_cnt + LP_ONE;
                        r_q     <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_LOW;
                    r_cnt   <= LP_ZERO;
                    r_q     <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign q    = r_q;
    assign busy = r_busy;

endmodule

// File: tb/tb_debounce.sv
// Self-checking bench for debounce: run-length reference model plus directed latency checks.
module tb_debounce;

    localparam int STABLE = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk;
    logic reset;
    logic d_raw;
    logic q;
    logic busy;

    int n_tests;
    int n_fail;
    int edge_n;

    // reference model: pipeline of raw samples, committed level, run length of the other level
    logic m_p1;
    logic m_p2;
    logic m_q;
    int   m_run;

    debounce #(.STABLE(STABLE), .CW(8)) dut (
        .clk  (clk),
        .reset(reset),
        .d_raw(d_raw),
        .q    (q),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_p1  = 1'b0;
        m_p2  = 1'b0;
        m_q   = 1'b0;
        m_run = 0;
    endtask

    // one clock: drive d, update model with what this edge samples, compare after the edge
    task automatic step(input logic d);
        logic s;
        d_raw = d;
        @(posedge clk);
        if (!reset) begin
            model_clear();
        end else begin
            if (LAT == 2) begin
                s    = m_p2;
                m_p2 = m_p1;
                m_p1 = d;
            end else begin
                s = d;
            end
            if (s != m_q) begin
                m_run++;
                if (m_run == STABLE) begin
                    m_q   = ~m_q;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        #1;
        edge_n++;
        chk("q_model", q, m_q);
        chk("busy_model", busy, (m_run != 0));
    endtask

    // asynchronous reset pulse placed between edges
    task automatic reset_pulse();
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        chk("q_async_rst", q, 1'b0);
        chk("busy_async_rst", busy, 1'b0);
        #1;
        reset = 1'b1;
    endtask

    int first_busy;
    int first_q;
    int busy_cnt;
    int q_cnt;
    int q_rises;
    logic prev_q;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        edge_n  = 0;
        model_clear();
        d_raw = 1'b1;
        reset = 1'b0;

        // reset held with input high: outputs stay low
        #1;
        chk("q_in_reset", q, 1'b0);
        chk("busy_in_reset", busy, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1);
        #2;
        reset = 1'b1;
        edge_n = 0;
        first_busy = -1;
        first_q = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1);
            if (busy && first_busy < 0) first_busy = edge_n;
            if (q && first_q < 0) first_q = edge_n;
        end
        chk_int("rst_rel_busy_edge", first_busy, LAT + 1);
        chk_int("rst_rel_q_edge", first_q, LAT + STABLE);

        // release bounce from HIGH: 0,0,1 then steady 0
        step(1'b0);
        step(1'b0);
        step(1'b1);
        chk("q_held_bounce", q, 1'b1);
        edge_n = 0;
        first_q = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0);
            if (!q && first_q < 0) first_q = edge_n;
        end
        chk_int("release_q_edge", first_q, LAT + STABLE);

        // glitch of STABLE-1 samples from LOW
        edge_n = 0;
        first_busy = -1;
        busy_cnt = 0;
        q_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            step((i < STABLE - 1) ? 1'b1 : 1'b0);
            if (busy) busy_cnt++;
            if (busy && first_busy < 0) first_busy = edge_n;
            if (q) q_cnt++;
        end
        chk_int("glitch_busy_cycles", busy_cnt, STABLE - 1);
        chk_int("glitch_busy_edge", first_busy, LAT + 1);
        chk_int("glitch_q_cycles", q_cnt, 0);

        // clean press (10) and release (12)
        edge_n = 0;
        first_q = -1;
        q_cnt = 0;
        q_rises = 0;
        prev_q = q;
        for (int i = 0; i < 22; i++) begin
            step((i < 10) ? 1'b1 : 1'b0);
            if (q && first_q < 0) first_q = edge_n;
            if (q) q_cnt++;
            if (q && !prev_q) q_rises++;
            prev_q = q;
        end
        chk_int("press_q_edge", first_q, LAT + STABLE);
        chk_int("press_q_cycles", q_cnt, 10);
        chk_int("press_q_rises", q_rises, 1);
        chk("press_q_final", q, 1'b0);

        // reset in the middle of a rise qualification (cnt=2)
        for (int i = 0; i < LAT + 2; i++) step(1'b1);
        chk("busy_mid_qual", busy, 1'b1);
        reset_pulse();
        edge_n = 0;
        first_q = -1;
        busy_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            if (busy) busy_cnt++;
        end
        chk_int("post_rst_busy", busy_cnt, 0);
        edge_n = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            if (q && first_q < 0) first_q = edge_n;
        end
        chk_int("post_rst_q_edge", first_q, LAT + STABLE);

        // randomized runs of random level and length, with occasional async resets
        for (int r = 0; r < 200; r++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, STABLE + 3);
            for (int k = 0; k < len; k++) begin
                if (($urandom % 8) == 0) step(~lvl);
                else step(lvl);
            end
            if (($urandom % 25) == 0) reset_pulse();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
